// File: rtl/req_ack_mon_pkg.sv
// Shared types and defaults for the req/ack handshake monitor.
package req_ack_mon_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned DEFAULT_MAX_LAT = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TOUT = 2'd2
  } state_e;

endpackage : req_ack_mon_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/req_ack_monitor.sv
// Single-outstanding req/ack monitor: measures latency, flags spurious acks,
// overlapping requests and timeouts, and keeps saturating event counters.
module req_ack_monitor
  import req_ack_mon_pkg::*;
#(
  parameter int unsigned MAX_LAT = DEFAULT_MAX_LAT,
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic [LAT_W-1:0] lat_o,
  output logic             lat_valid_o,
  output logic             timeout_o,
  output logic             err_spur_o,
  output logic             err_overlap_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0] lat_d;
  logic             lat_valid_d, timeout_d, spur_d, overlap_d;
  logic             done_inc, err_inc;

  // Next-state, latency counter and event decode
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    lat_d       = lat_o;
    lat_valid_d = 1'b0;
    timeout_d   = 1'b0;
    spur_d      = 1'b0;
    overlap_d   = 1'b0;
    done_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i && ack_i) begin
          lat_d       = '0;
          lat_valid_d = 1'b1;
          done_inc    = 1'b1;
        end else if (req_i) begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_ONE;
        end else if (ack_i) begin
          spur_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ack_i) begin
          lat_d       = lat_cnt_q;
          lat_valid_d = 1'b1;
          done_inc    = 1'b1;
          // A coincident req immediately opens the next transaction
          if (req_i) lat_cnt_d = LAT_ONE;
          else       state_d   = ST_IDLE;
        end else begin
          overlap_d = req_i;
          if (lat_cnt_q == LAT_MAX) begin
            state_d   = ST_TOUT;
            timeout_d = 1'b1;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_ONE;
          end
        end
      end
      ST_TOUT: begin
        if (ack_i) state_d = ST_IDLE;
        else       overlap_d = req_i;
      end
      default: state_d = ST_IDLE;
    endcase

    err_inc = spur_d | overlap_d | timeout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= '0;
      lat_o         <= '0;
      lat_valid_o   <= 1'b0;
      timeout_o     <= 1'b0;
      err_spur_o    <= 1'b0;
      err_overlap_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      lat_o         <= lat_d;
      lat_valid_o   <= lat_valid_d;
      timeout_o     <= timeout_d;
      err_spur_o    <= spur_d;
      err_overlap_o <= overlap_d;
      busy_o        <= (state_d != ST_IDLE);
    end
  end

  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clk (clk),
    .rst (rst),
    .inc (done_inc),
    .clr (clr_i),
    .q   (done_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (clr_i),
    .q   (err_cnt_o)
  );

endmodule : req_ack_monitor

// File: tb/tb_req_ack_monitor.sv
// Bench for req_ack_monitor: timestamp-based model plus directed literal checks,
// run on an 8-bit-counter instance and a 2-bit-counter instance in parallel.
module tb_req_ack_monitor;

  localparam int unsigned MAX_LAT = 8;
  localparam int unsigned LAT_W   = 4;

  logic clk, rst, req_i, ack_i, clr_i;

  logic             busy_a, lv_a, to_a, sp_a, ov_a;
  logic [LAT_W-1:0] lat_a;
  logic [7:0]       done_a, err_a;

  logic             busy_b, lv_b, to_b, sp_b, ov_b;
  logic [LAT_W-1:0] lat_b;
  logic [1:0]       done_b, err_b;

  int checks = 0;
  int errors = 0;

  req_ack_monitor #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_i(ack_i), .clr_i(clr_i),
    .busy_o(busy_a), .lat_o(lat_a), .lat_valid_o(lv_a), .timeout_o(to_a),
    .err_spur_o(sp_a), .err_overlap_o(ov_a), .done_cnt_o(done_a), .err_cnt_o(err_a)
  );

  req_ack_monitor #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_i(req_i), .ack_i(ack_i), .clr_i(clr_i),
    .busy_o(busy_b), .lat_o(lat_b), .lat_valid_o(lv_b), .timeout_o(to_b),
    .err_spur_o(sp_b), .err_overlap_o(ov_b), .done_cnt_o(done_b), .err_cnt_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding request tracked by its start cycle number
  int  cyc_n = 0, t0 = 0;
  bit  outst = 0, timed = 0;
  int  m_lat = 0, m_done8 = 0, m_err8 = 0, m_done2 = 0, m_err2 = 0;
  bit  m_lv, m_to, m_sp, m_ov;

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    cyc_n++;
    m_lv = 0; m_to = 0; m_sp = 0; m_ov = 0;
    if (rst) begin
      outst = 0; timed = 0; m_lat = 0;
      m_done8 = 0; m_err8 = 0; m_done2 = 0; m_err2 = 0;
    end else begin
      if (!outst) begin
        if (req_i && ack_i) begin m_lat = 0; m_lv = 1; end
        else if (req_i) begin outst = 1; t0 = cyc_n; end
        else if (ack_i) m_sp = 1;
      end else if (!timed) begin
        if (ack_i) begin
          m_lat = cyc_n - t0; m_lv = 1;
          if (req_i) t0 = cyc_n; else outst = 0;
        end else begin
          m_ov = req_i;
          if (cyc_n - t0 == int'(MAX_LAT)) begin timed = 1; m_to = 1; end
        end
      end else begin
        if (ack_i) begin outst = 0; timed = 0; end
        else m_ov = req_i;
      end
      if (m_lv) begin m_done8 = sat_inc(m_done8, 255); m_done2 = sat_inc(m_done2, 3); end
      if (m_sp || m_ov || m_to) begin m_err8 = sat_inc(m_err8, 255); m_err2 = sat_inc(m_err2, 3); end
      if (clr_i) begin m_done8 = 0; m_err8 = 0; m_done2 = 0; m_err2 = 0; end
    end
    #1;
    chk("busy",      int'(busy_a), int'(outst));
    chk("lat",       int'(lat_a),  m_lat);
    chk("lat_valid", int'(lv_a),   int'(m_lv));
    chk("timeout",   int'(to_a),   int'(m_to));
    chk("spur",      int'(sp_a),   int'(m_sp));
    chk("overlap",   int'(ov_a),   int'(m_ov));
    chk("done8",     int'(done_a), m_done8);
    chk("err8",      int'(err_a),  m_err8);
    chk("busy_s",    int'(busy_b), int'(outst));
    chk("lat_s",     int'(lat_b),  m_lat);
    chk("done2",     int'(done_b), m_done2);
    chk("err2",      int'(err_b),  m_err2);
  end

  // Drive one cycle of inputs; returns 2 time units after the sampling edge
  task automatic step(input logic r, input logic a, input logic c);
    req_i = r; ack_i = a; clr_i = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; ack_i = 1'b0; clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_lat",  int'(lat_a),  0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err",  int'(err_a),  0);
    rst = 1'b0;

    // Reset in the middle of an outstanding request
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("midwait_busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    chk("async_busy", int'(busy_a), 0);
    chk("async_lv",   int'(lv_a),   0);
    chk("async_lat",  int'(lat_a),  0);
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 1, 0);
    chk("spur_after_rst", int'(sp_a),  1);
    chk("err_after_rst",  int'(err_a), 1);
    step(0, 0, 1);
    chk("clr_err", int'(err_a), 0);

    // Periodic stream: req at slot 1, ack at slot 6, period 16
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 16; s++) begin
        step(s == 1, s == 6, 0);
        if (s == 6) begin
          chk("stream_lv",  int'(lv_a),  1);
          chk("stream_lat", int'(lat_a), 5);
        end
      end
    end
    chk("stream_done",  int'(done_a), 4);
    chk("stream_err",   int'(err_a),  0);
    chk("stream_done2", int'(done_b), 3);

    // Timeout then late ack
    step(0, 0, 1);
    step(1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0);
      chk("tout_pulse", int'(to_a),   (k == 8) ? 1 : 0);
      chk("tout_busy",  int'(busy_a), 1);
    end
    step(0, 1, 0);
    chk("late_ack_lv",   int'(lv_a),   0);
    chk("late_ack_spur", int'(sp_a),   0);
    chk("late_ack_busy", int'(busy_a), 0);
    chk("tout_err",      int'(err_a),  1);
    chk("tout_done",     int'(done_a), 0);

    // Ack exactly at the latency limit completes normally
    step(0, 0, 1);
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    step(0, 1, 0);
    chk("maxlat_lat", int'(lat_a), 8);
    chk("maxlat_to",  int'(to_a),  0);
    chk("maxlat_err", int'(err_a), 0);

    // Back-to-back with ack&req restart
    step(0, 0, 1);
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    step(1, 1, 0);
    chk("b2b_lat1", int'(lat_a),  3);
    chk("b2b_ov",   int'(ov_a),   0);
    chk("b2b_busy", int'(busy_a), 1);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("b2b_lat2", int'(lat_a),  2);
    chk("b2b_done", int'(done_a), 2);
    chk("b2b_err",  int'(err_a),  0);

    // Overlapping req, then zero-latency completion in IDLE
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("ovl_pulse", int'(ov_a), 1);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("ovl_lat", int'(lat_a), 3);
    step(1, 1, 0);
    chk("zero_lat",  int'(lat_a),  0);
    chk("zero_lv",   int'(lv_a),   1);
    chk("zero_done", int'(done_a), 2);
    chk("zero_err",  int'(err_a),  1);

    // Saturation of the 2-bit counter, then clear beating an increment
    step(0, 0, 1);
    repeat (5) step(0, 1, 0);
    chk("sat_err2", int'(err_b), 3);
    chk("sat_err8", int'(err_a), 5);
    step(0, 1, 1);
    chk("clr_spur",  int'(sp_b),  1);
    chk("clr_err2",  int'(err_b), 0);
    chk("clr_err8",  int'(err_a), 0);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_req_ack_monitor

// File: doc/req_ack_monitor.md
Name: req_ack_monitor

Overview:
- Downstream consumer of the free-running stimulus counter's handshake outputs, e.g. the req/ack pulse pair.
- Tracks one outstanding request at a time and measures request-to-acknowledge latency in clock cycles.
- Flags protocol violations and timeouts, and keeps saturating completion and error counters.
- Gives the formal/simulation environment a concrete sequential DUT whose properties are driven by the counter's waveforms.

Parameters:
MAX_LAT, 8, cycles allowed from req to ack before timeout (>=2)
LAT_W, 4, width of latency output/counter; must hold MAX_LAT
CNT_W, 8, width of completion/error counters

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  1  request pulse/level, sampled each edge
ack_i  input  1  acknowledge pulse/level, sampled each edge
clr_i  input  1  synchronous clear of done_cnt_o/err_cnt_o only
busy_o  output  1  high while in WAIT or TOUT
lat_o  output  LAT_W  latency of last completed transaction; holds until next completion
lat_valid_o  output  1  one-cycle pulse when lat_o updates
timeout_o  output  1  one-cycle pulse on timeout
err_spur_o  output  1  one-cycle pulse: ack with no request outstanding
err_overlap_o  output  1  one-cycle pulse: req while request outstanding
done_cnt_o  output  CNT_W  completed transactions, saturating
err_cnt_o  output  CNT_W  total errors (spur+overlap+timeout), saturating

Behaviour:
- Reset (async, rst=1): state=IDLE, lat counter=0, lat_o=0, all pulses 0, busy_o=0, both counters 0. Deassertion is taken synchronously on the next edge.
- All outputs are registered. A response to inputs sampled at edge N is visible after edge N.
- FSM states IDLE, WAIT, TOUT; 2-bit encoding.
- IDLE:
  - req&!ack -> WAIT, lat counter=1.
  - req&ack -> zero-latency completion: lat_o=0, lat_valid_o, done_cnt++, stay IDLE.
  - !req&ack -> err_spur_o, err_cnt++.
- WAIT:
  - ack&!req -> IDLE; lat_o=lat counter, lat_valid_o, done_cnt++.
  - ack&req -> complete as above, then immediately start new request: stay WAIT, lat counter=1. No overlap error.
  - req&!ack -> err_overlap_o, err_cnt++; request ignored, latency keeps counting the original.
  - Neither: lat counter++. If lat counter==MAX_LAT without ack -> TOUT; timeout_o, err_cnt++.
- TOUT:
  - busy_o stays 1, lat counter frozen.
  - ack -> IDLE, no lat_valid_o, no done_cnt++ (late ack absorbed, not spurious).
  - req without ack -> err_overlap_o.
- Latency definition: number of rising edges from the edge sampling req to the edge sampling ack. Example: req at count 1, ack at count 6 gives lat_o=5.
- Simultaneous error events in one cycle: each pulse asserts independently; err_cnt increments by 1 per cycle maximum.
- Counters saturate at all-ones, with no wrap.
- clr_i has priority over a same-cycle increment (result 0). clr_i does not affect FSM, lat_o or pulses.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Decomposition:
- Package req_ack_mon_pkg: state enum type (IDLE/WAIT/TOUT), state width constant, default MAX_LAT.
- Sub-module sat_counter (parameter W; inputs inc, clr; output q; clr priority, saturate at 2^W-1), instantiated twice for done_cnt_o and err_cnt_o.
- FSM and latency counter stay in the top module.

Test Plan:
- Reset mid-WAIT: req, 3 idle cycles, assert rst -> busy_o=0 immediately, all outputs 0; after release, ack alone -> err_spur_o=1, err_cnt_o=1.
- Counter-style stream: req pulse at cycle 1, ack at cycle 6, period 16, 4 periods -> lat_valid_o four times with lat_o=5, done_cnt_o=4, err_cnt_o=0.
- Timeout: MAX_LAT=8, req then no ack for 10 cycles, then ack -> timeout_o one cycle, 8 cycles after the req edge; busy_o held; late ack returns to IDLE with no lat_valid_o; err_cnt_o=1, done_cnt_o=0.
- Back-to-back: req; ack&req 3 cycles later; ack 2 cycles after that -> lat_o=3 then lat_o=2; done_cnt_o=2; no err_overlap_o.
- Overlap plus same-cycle req&ack in IDLE: req, req after 1 cycle, ack after 3 -> err_overlap_o once, lat_o=3; then req&ack together -> lat_o=0, done_cnt_o=2, err_cnt_o=1.
- Saturation/clear: CNT_W=2, 5 spurious acks -> err_cnt_o holds at 3; clr_i coincident with a spurious ack -> err_cnt_o=0.
